// File: rtl/wallace_mul_arbiter_if.sv
// Requester-side request/response bundle for wallace_mul_arbiter.
// The arbiter takes the slave modport; requesters use master.
interface wallace_mul_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 6
);
   localparam int unsigned PW = 13;

   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*W-1:0]  req_a;
   logic [NREQ*W-1:0]  req_b;
   logic [NREQ-1:0]    rsp_valid;
   logic [NREQ-1:0]    rsp_ready;
   logic [NREQ*PW-1:0] rsp_p;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_p
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_p
   );
endinterface

// File: rtl/wallace_mul_arbiter.sv
// Round-robin arbiter sharing one registered 6x6 multiplier among NREQ requesters,
// with a latency-matched tag pipeline and per-requester result registers.
module wallace_mul_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 6,
   parameter int unsigned LAT  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   wallace_mul_arbiter_if.slave bus,
   output logic [W-1:0]        mul_a,
   output logic [W-1:0]        mul_b,
   input  logic [12:0]         mul_p,
   output logic                busy
);
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned PW = 13;

   logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [LAT-1:0]         tag_vld_q, tag_vld_d;
   logic [LAT-1:0][IW-1:0] tag_idx_q, tag_idx_d;
   logic [NREQ-1:0]        inflight_q, inflight_d;
   logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
   logic [NREQ*PW-1:0]     rsp_p_q, rsp_p_d;
   logic                   busy_q, busy_d;

   logic [NREQ-1:0]        elig_c;
   logic                   gnt_vld_c;
   logic [IW-1:0]          gnt_idx_c;
   int unsigned            cand_c;
   logic                   cap_c;
   logic [IW-1:0]          cap_idx_c;

   // Grants are suppressed during reset so req_ready reads 0 while rst_n is low.
   assign elig_c    = bus.req_valid & ~(inflight_q | rsp_valid_q) & {NREQ{rst_n}};
   assign cap_c     = tag_vld_q[LAT-1];
   assign cap_idx_c = tag_idx_q[LAT-1];

   // First eligible requester at or after rr_ptr, with wrap-around.
   always_comb begin
      gnt_vld_c = 1'b0;
      gnt_idx_c = '0;
      cand_c    = 0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         cand_c = (32'(rr_ptr_q) + off) % NREQ;
         if (!gnt_vld_c && elig_c[IW'(cand_c)]) begin
            gnt_vld_c = 1'b1;
            gnt_idx_c = IW'(cand_c);
         end
      end
   end

   assign bus.req_ready = gnt_vld_c ? (NREQ'(1) << gnt_idx_c) : '0;
   assign mul_a         = gnt_vld_c ? bus.req_a[gnt_idx_c*W +: W] : '0;
   assign mul_b         = gnt_vld_c ? bus.req_b[gnt_idx_c*W +: W] : '0;

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      tag_vld_d   = '0;
      tag_idx_d   = '0;
      inflight_d  = inflight_q;
      rsp_valid_d = rsp_valid_q & ~bus.rsp_ready;
      rsp_p_d     = rsp_p_q;

      tag_vld_d[0] = gnt_vld_c;
      tag_idx_d[0] = gnt_idx_c;
      for (int unsigned s = 1; s < LAT; s++) begin
         tag_vld_d[s] = tag_vld_q[s-1];
         tag_idx_d[s] = tag_idx_q[s-1];
      end

      // A capture never targets a held response: the index was not eligible while pending.
      if (cap_c) begin
         inflight_d[cap_idx_c]          = 1'b0;
         rsp_valid_d[cap_idx_c]         = 1'b1;
         rsp_p_d[cap_idx_c*PW +: PW]    = mul_p;
      end

      if (gnt_vld_c) begin
         inflight_d[gnt_idx_c] = 1'b1;
         rr_ptr_d = (gnt_idx_c == IW'(NREQ - 1)) ? '0 : gnt_idx_c + IW'(1);
      end

      busy_d = (|inflight_d) | (|rsp_valid_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         tag_vld_q   <= '0;
         tag_idx_q   <= '0;
         inflight_q  <= '0;
         rsp_valid_q <= '0;
         rsp_p_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         tag_vld_q   <= tag_vld_d;
         tag_idx_q   <= tag_idx_d;
         inflight_q  <= inflight_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_p_q     <= rsp_p_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_p     = rsp_p_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Directed bench for wallace_mul_arbiter: external 2-stage multiplier model,
// cycle-level scoreboard of grants/results, plus literal expectations per scenario.
module tb_wallace_mul_arbiter;
   localparam int unsigned NREQ = 4;
   localparam int unsigned W    = 6;
   localparam int unsigned PW   = 13;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   wallace_mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();
   logic [W-1:0] mul_a, mul_b;
   logic [12:0]  mul_p;
   logic         busy;

   // Multiplier stand-in: operand register, then product register, no reset.
   logic [W-1:0] m_ra, m_rb;
   logic [12:0]  m_rp;
   always @(posedge clk) begin
      m_ra <= mul_a;
      m_rb <= mul_b;
      m_rp <= 13'(m_ra) * 13'(m_rb);
   end
   assign mul_p = m_rp;

   wallace_mul_arbiter #(.NREQ(NREQ), .W(W), .LAT(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .mul_a (mul_a),
      .mul_b (mul_b),
      .mul_p (mul_p),
      .busy  (busy)
   );

   int n_err = 0;
   int n_chk = 0;
   int cyc   = 0;

   // Scoreboard: per-requester state in plain terms.
   int m_ptr;
   bit m_inf  [NREQ];
   int m_gcyc [NREQ];
   int m_prod [NREQ];
   bit m_rv   [NREQ];
   int m_rp_v [NREQ];

   logic [NREQ-1:0]    obs_ready, obs_rv;
   logic [NREQ*PW-1:0] obs_p;
   logic               obs_busy;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_cycle();
      int g;
      int c;
      logic [NREQ-1:0]    er, erv;
      logic [W-1:0]       ea, eb;
      logic [NREQ*PW-1:0] ep;
      logic               ebusy;
      if (!rst_n) begin
         chk("rst_ready", 64'(bus.req_ready), 64'(0));
         chk("rst_mul_a", 64'(mul_a), 64'(0));
         chk("rst_mul_b", 64'(mul_b), 64'(0));
         chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
         chk("rst_rsp_p", 64'(bus.rsp_p), 64'(0));
         chk("rst_busy", 64'(busy), 64'(0));
         m_ptr = 0;
         for (int i = 0; i < NREQ; i++) begin
            m_inf[i] = 0; m_rv[i] = 0; m_rp_v[i] = 0;
         end
         return;
      end
      g = -1;
      for (int off = 0; off < NREQ; off++) begin
         c = (m_ptr + off) % NREQ;
         if (g < 0 && bus.req_valid[c] && !m_inf[c] && !m_rv[c]) g = c;
      end
      er = '0; ea = '0; eb = '0;
      if (g >= 0) begin
         er[g] = 1'b1;
         ea = bus.req_a[g*W +: W];
         eb = bus.req_b[g*W +: W];
      end
      ebusy = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         erv[i] = m_rv[i];
         ep[i*PW +: PW] = PW'(m_rp_v[i]);
         if (m_inf[i] || m_rv[i]) ebusy = 1'b1;
      end
      chk("req_ready", 64'(bus.req_ready), 64'(er));
      chk("mul_a", 64'(mul_a), 64'(ea));
      chk("mul_b", 64'(mul_b), 64'(eb));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(erv));
      chk("rsp_p", 64'(bus.rsp_p), 64'(ep));
      chk("busy", 64'(busy), 64'(ebusy));
      for (int i = 0; i < NREQ; i++)
         if (m_rv[i] && bus.rsp_ready[i]) m_rv[i] = 0;
      for (int i = 0; i < NREQ; i++) begin
         if (m_inf[i] && cyc == m_gcyc[i] + 2) begin
            chk("no_collision", 64'(bus.rsp_valid[i]), 64'(0));
            m_inf[i] = 0; m_rv[i] = 1; m_rp_v[i] = m_prod[i];
         end
      end
      if (g >= 0) begin
         m_inf[g]  = 1;
         m_gcyc[g] = cyc;
         m_prod[g] = int'(ea) * int'(eb);
         m_ptr     = (g + 1) % NREQ;
      end
   endtask

   // One clock: sample and score on the falling edge, advance past the rising edge.
   task automatic step();
      logic [NREQ-1:0] xfer;
      @(negedge clk);
      obs_ready = bus.req_ready;
      obs_rv    = bus.rsp_valid;
      obs_p     = bus.rsp_p;
      obs_busy  = busy;
      xfer      = bus.req_valid & bus.req_ready;
      model_cycle();
      @(posedge clk);
      #1;
      cyc++;
      bus.req_valid = bus.req_valid & ~xfer;
   endtask

   task automatic set_req(input int i, input int a, input int b);
      bus.req_valid[i]     = 1'b1;
      bus.req_a[i*W +: W]  = W'(a);
      bus.req_b[i*W +: W]  = W'(b);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = '1;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Lone request on an idle arbiter: grant in cycle 0, result in cycle 3.
   task automatic run_one(input int i, input int a, input int b, input int exp);
      set_req(i, a, b);
      step();
      chk("one_grant", 64'(obs_ready), 64'(1) << i);
      chk("one_busy0", 64'(obs_busy), 64'(0));
      for (int c = 1; c <= 3; c++) begin
         step();
         chk("one_busy", 64'(obs_busy), 64'(1));
         chk("one_rv", 64'(obs_rv[i]), (c == 3) ? 64'(1) : 64'(0));
      end
      chk("one_p", 64'(obs_p[i*PW +: PW]), 64'(exp));
      step();
      chk("one_idle", 64'(obs_busy), 64'(0));
   endtask

   int served0, served2;

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = '1;

      // Single request and operand extremes.
      do_reset();
      run_one(0, 5, 7, 35);
      run_one(2, 63, 63, 3969);
      run_one(2, 0, 42, 0);

      // Full contention from reset.
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, i + 1, i + 2);
      for (int c = 0; c < 4; c++) begin
         step();
         chk("cont_grant", 64'(obs_ready), 64'(1) << c);
      end
      chk("cont_rv3", 64'(obs_rv), 64'(1));
      chk("cont_p0", 64'(obs_p[0 +: PW]), 64'(2));
      for (int i = 0; i < NREQ; i++) set_req(i, 10 + i, 3);
      step();
      chk("cont_regrant0", 64'(obs_ready), 64'(1));
      chk("cont_rv4", 64'(obs_rv), 64'(2));
      step();
      chk("cont_regrant1", 64'(obs_ready), 64'(2));
      chk("cont_rv5", 64'(obs_rv), 64'(4));
      step();
      chk("cont_regrant2", 64'(obs_ready), 64'(4));
      chk("cont_rv6", 64'(obs_rv), 64'(8));
      chk("cont_p3", 64'(obs_p[3*PW +: PW]), 64'(20));
      for (int k = 0; k < 8; k++) step();

      // Fairness: pointer left at 2 by a grant to requester 1.
      do_reset();
      run_one(1, 4, 4, 16);
      set_req(0, 3, 3);
      set_req(3, 5, 5);
      step();
      chk("fair_first3", 64'(obs_ready), 64'(8));
      step();
      chk("fair_then0", 64'(obs_ready), 64'(1));
      for (int k = 0; k < 6; k++) step();

      // Response backpressure on requester 1.
      do_reset();
      bus.rsp_ready[1] = 1'b0;
      set_req(1, 11, 13);
      for (int k = 0; k < 4; k++) step();
      chk("bp_rv1", 64'(obs_rv[1]), 64'(1));
      chk("bp_p1", 64'(obs_p[PW +: PW]), 64'(143));
      set_req(1, 9, 9);
      served0 = 0;
      served2 = 0;
      for (int k = 0; k < 6; k++) begin
         if (!bus.req_valid[0]) set_req(0, 2, 3);
         if (!bus.req_valid[2]) set_req(2, 7, 6);
         step();
         chk("bp_hold_ready1", 64'(obs_ready[1]), 64'(0));
         chk("bp_hold_p1", 64'(obs_p[PW +: PW]), 64'(143));
         if (obs_ready[0]) served0++;
         if (obs_ready[2]) served2++;
      end
      chk("bp_served0", 64'(served0 >= 1), 64'(1));
      chk("bp_served2", 64'(served2 >= 1), 64'(1));
      bus.req_valid[0] = 1'b0;
      bus.req_valid[2] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_drain_ready1", 64'(obs_ready[1]), 64'(0));
      end
      bus.rsp_ready[1] = 1'b1;
      step();
      chk("bp_release_cycle", 64'(obs_ready[1]), 64'(0));
      step();
      chk("bp_regrant1", 64'(obs_ready[1]), 64'(1));
      for (int k = 0; k < 5; k++) step();
      chk("bp_new_p1", 64'(bus.rsp_p[PW +: PW]), 64'(81));

      // Reset in cycle 1 after a grant in cycle 0.
      do_reset();
      set_req(0, 7, 8);
      step();
      chk("rmf_grant", 64'(obs_ready), 64'(1));
      bus.req_valid[3] = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("rmf_async_busy", 64'(busy), 64'(0));
      chk("rmf_async_ready", 64'(bus.req_ready), 64'(0));
      chk("rmf_async_rv", 64'(bus.rsp_valid), 64'(0));
      step();
      step();
      bus.req_valid = '0;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rmf_no_rv", 64'(obs_rv), 64'(0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
